// File: rtl/sfifo_pkg.sv
//------------------------------------------------------------------------------
// Module   : sfifo_pkg
// Purpose  : Shared constants and FSM encoding for the sfifo write arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sfifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int FIFO_DEPTH = 64;
  localparam int ARB_DEPTH  = 62;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    STALL = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/sfifo_rr_pick.sv
//------------------------------------------------------------------------------
// Module   : sfifo_rr_pick
// Purpose  : Combinational pick of the first eligible bit at or after i_ptr,
//            wrapping modulo N. Returns a one-hot select and a valid flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sfifo_rr_pick
  import sfifo_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_elig,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_onehot,
  output logic             o_valid
);

  int w_best_d;
  int w_best_i;
  int w_d;

  // Smallest forward distance from the pointer wins.
  always_comb begin
    w_best_d = N;
    w_best_i = 0;
    w_d      = 0;
    for (int i = 0; i < N; i++) begin
      w_d = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + N - int'(i_ptr));
      if (i_elig[i] && (w_d < w_best_d)) begin
        w_best_d = w_d;
        w_best_i = i;
      end
    end
    o_valid  = (w_best_d < N);
    o_onehot = o_valid ? (N'(1) << w_best_i) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/sfifo_wr_arb.sv
//------------------------------------------------------------------------------
// Module   : sfifo_wr_arb
// Purpose  : Round-robin write arbiter for one sfifo write port with a credit
//            counter that prevents writes into a full FIFO.
//            Optional macro SFIFO_ARB_PRIO_EN: requester 0 has strict priority.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sfifo_wr_arb
  import sfifo_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = ARB_DEPTH,
  parameter int CNT_W  = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] din,
  output logic [NREQ-1:0]        gnt,
  output logic                   fifo_w_en,
  output logic [DATA_W-1:0]      fifo_din,
  input  logic                   fifo_pop,
  output logic                   credit_zero,
  output logic [CNT_W-1:0]       occupancy,
  output logic                   pop_err
);

  localparam int               PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [NREQ-1:0]   r_gnt;
  logic              r_wen;
  logic [DATA_W-1:0] r_dout;
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_cz;
  logic              r_perr;

  logic [NREQ-1:0]   w_elig;
  logic [NREQ-1:0]   w_rr_elig;
  logic [NREQ-1:0]   w_rr_oh;
  logic              w_rr_vld;
  logic [NREQ-1:0]   w_sel;
  logic              w_sel_vld;
  logic              w_keep_ptr;
  logic [PTR_W-1:0]  w_idx;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [DATA_W-1:0] w_din_sel;
  logic              w_fire;
  logic              w_pop_ok;
  logic [CNT_W-1:0]  w_count_nxt;

  // A requester granted last edge has not yet reacted to its grant.
  assign w_elig = req & ~r_gnt;

`ifdef SFIFO_ARB_PRIO_EN
  assign w_rr_elig  = w_elig & ~NREQ'(1);
  assign w_sel      = w_elig[0] ? NREQ'(1) : w_rr_oh;
  assign w_sel_vld  = w_elig[0] | w_rr_vld;
  assign w_keep_ptr = w_elig[0];
`else
  assign w_rr_elig  = w_elig;
  assign w_sel      = w_rr_oh;
  assign w_sel_vld  = w_rr_vld;
  assign w_keep_ptr = 1'b0;
`endif

  sfifo_rr_pick #(
    .N     (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_elig   (w_rr_elig),
    .i_ptr    (r_ptr),
    .o_onehot (w_rr_oh),
    .o_valid  (w_rr_vld)
  );

  always_comb begin
    w_idx     = '0;
    w_din_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel[i]) begin
        w_idx     = PTR_W'(i);
        w_din_sel = din[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_ptr_nxt = (w_idx == PTR_W'(NREQ - 1)) ? '0 : (w_idx + PTR_W'(1));
  assign w_fire    = enable && (r_state == ARB) && (r_count < c_depth) && w_sel_vld;
  assign w_pop_ok  = fifo_pop && (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_fire && !w_pop_ok) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_fire && w_pop_ok) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Transitions look at the post-edge count so a pop at DEPTH re-arms at once.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = (w_count_nxt == c_depth) ? STALL : ARB;
        ARB:     if (w_count_nxt == c_depth) w_state_nxt = STALL;
        STALL:   if (w_count_nxt != c_depth) w_state_nxt = ARB;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_wen   <= 1'b0;
      r_dout  <= '0;
      r_ptr   <= '0;
      r_count <= '0;
      r_cz    <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_fire ? w_sel : '0;
      r_wen   <= w_fire;
      if (w_fire) begin
        r_dout <= w_din_sel;
      end
      if (w_fire && !w_keep_ptr) begin
        r_ptr <= w_ptr_nxt;
      end
      r_count <= w_count_nxt;
      r_cz    <= (w_count_nxt == c_depth);
      if (fifo_pop && (r_count == '0)) begin
        r_perr <= 1'b1;
      end
    end
  end

  assign gnt         = r_gnt;
  assign fifo_w_en   = r_wen;
  assign fifo_din    = r_dout;
  assign credit_zero = r_cz;
  assign occupancy   = r_count;
  assign pop_err     = r_perr;

endmodule

`default_nettype wire

// File: tb/tb_sfifo_wr_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_sfifo_wr_arb
// Purpose  : Self-checking bench for sfifo_wr_arb against a behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sfifo_wr_arb;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 62;
  localparam int CW    = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic              fifo_pop = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] din = '0;
  logic [NREQ-1:0]   gnt;
  logic              fifo_w_en;
  logic [DW-1:0]     fifo_din;
  logic              credit_zero;
  logic [CW-1:0]     occupancy;
  logic              pop_err;

  always #5 clk = ~clk;

  sfifo_wr_arb #(
    .NREQ   (NREQ),
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req         (req),
    .din         (din),
    .gnt         (gnt),
    .fifo_w_en   (fifo_w_en),
    .fifo_din    (fifo_din),
    .fifo_pop    (fifo_pop),
    .credit_zero (credit_zero),
    .occupancy   (occupancy),
    .pop_err     (pop_err)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: arbiter is live one edge after enable is seen high.
  bit              m_active;
  logic [NREQ-1:0] m_gnt;
  int              m_ptr;
  int              m_count;
  logic            m_perr;
  logic            m_wen;
  logic [DW-1:0]   m_dout;

  task automatic model_reset();
    m_active = 1'b0;
    m_gnt    = '0;
    m_ptr    = 0;
    m_count  = 0;
    m_perr   = 1'b0;
    m_wen    = 1'b0;
    m_dout   = '0;
  endtask

  task automatic step();
    int              pick;
    int              idx;
    bit              keep;
    int              pop_ok;
    logic [NREQ-1:0] elig;
    pick = -1;
    keep = 1'b0;
    elig = req & ~m_gnt;
    if (m_active && enable && (m_count < DEPTH)) begin
`ifdef SFIFO_ARB_PRIO_EN
      if (elig[0]) begin
        pick = 0;
        keep = 1'b1;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (pick < 0 && idx != 0 && ((elig >> idx) & 1) != 0) pick = idx;
        end
      end
`else
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (pick < 0 && ((elig >> idx) & 1) != 0) pick = idx;
      end
`endif
    end
    if (fifo_pop && m_count == 0) m_perr = 1'b1;
    pop_ok  = (fifo_pop && m_count > 0) ? 1 : 0;
    m_count = m_count + ((pick >= 0) ? 1 : 0) - pop_ok;
    m_wen   = (pick >= 0);
    m_gnt   = (pick >= 0) ? NREQ'(1 << pick) : '0;
    if (pick >= 0) begin
      m_dout = DW'(din >> (pick * DW));
      if (!keep) m_ptr = (pick + 1) % NREQ;
    end
    m_active = enable;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    req      = '0;
    enable   = 1'b0;
    fifo_pop = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %0h expected 0", gnt); end
    checks++; if (fifo_w_en !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0b expected 0", fifo_w_en); end
    checks++; if (occupancy !== 7'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    checks++; if (pop_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %0b expected 0", pop_err); end
    checks++; if (credit_zero !== 1'b0) begin errors++; $display("FAIL reset_cz: got %0b expected 0", credit_zero); end
    checks++; if (fifo_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %0h expected 0", fifo_din); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    int extra;
    enable = 1'b1;
    din    = 32'h3C5A_0F77;
    din[15:8] = 8'hA5;
    step();
    req = 4'b0010;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt: got %0h expected 2", gnt); end
    checks++; if (fifo_w_en !== 1'b1) begin errors++; $display("FAIL single_wen: got %0b expected 1", fifo_w_en); end
    checks++; if (fifo_din !== 8'hA5) begin errors++; $display("FAIL single_din: got %0h expected a5", fifo_din); end
    req   = 4'b0000;
    extra = 0;
    repeat (5) begin
      step();
      if (gnt !== 4'b0 || fifo_w_en !== 1'b0) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL single_extra: got %0d extra grant cycles expected 0", extra); end
    checks++; if (fifo_din !== 8'hA5) begin errors++; $display("FAIL single_hold: got %0h expected a5", fifo_din); end
    checks++; if (occupancy !== 7'd1) begin errors++; $display("FAIL single_occ: got %0d expected 1", occupancy); end
  endtask

  task automatic test_all_four();
    int              dcnt [NREQ];
    int              mcnt [NREQ];
    logic [NREQ-1:0] prev;
    int              bad;
    for (int i = 0; i < NREQ; i++) begin
      dcnt[i] = 0;
      mcnt[i] = 0;
    end
    prev = '0;
    bad  = 0;
    req  = 4'b1111;
    repeat (40) begin
      step();
      checks++; if (gnt !== m_gnt) begin errors++; $display("FAIL all4_gnt: got %0h expected %0h", gnt, m_gnt); end
      if (gnt != 4'b0 && gnt == prev) bad++;
      prev = gnt;
      for (int i = 0; i < NREQ; i++) begin
        if (((gnt >> i) & 1) != 0) dcnt[i]++;
        if (((m_gnt >> i) & 1) != 0) mcnt[i]++;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL all4_repeat: got %0d repeats expected 0", bad); end
    for (int i = 0; i < NREQ; i++) begin
      checks++; if (dcnt[i] !== mcnt[i]) begin errors++; $display("FAIL all4_count[%0d]: got %0d expected %0d", i, dcnt[i], mcnt[i]); end
    end
    req = '0;
  endtask

  task automatic test_grant_pop();
    int guard;
    do_reset();
    enable = 1'b1;
    req    = 4'b0001;
    guard  = 0;
    while (m_count < 30 && guard < 200) begin
      step();
      guard++;
    end
    checks++; if (occupancy !== 7'd30) begin errors++; $display("FAIL gp_setup: got %0d expected 30", occupancy); end
    step();
    fifo_pop = 1'b1;
    step();
    fifo_pop = 1'b0;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL gp_gnt: got %0h expected 1", gnt); end
    checks++; if (occupancy !== 7'd30) begin errors++; $display("FAIL gp_occ: got %0d expected 30", occupancy); end
    req = '0;
  endtask

  task automatic test_credit();
    int g;
    do_reset();
    enable = 1'b1;
    req    = 4'b0001;
    g      = 0;
    repeat (140) begin
      step();
      if (gnt[0]) g++;
    end
    checks++; if (g !== 62) begin errors++; $display("FAIL credit_grants: got %0d expected 62", g); end
    checks++; if (occupancy !== 7'd62) begin errors++; $display("FAIL credit_occ: got %0d expected 62", occupancy); end
    checks++; if (credit_zero !== 1'b1) begin errors++; $display("FAIL credit_cz: got %0b expected 1", credit_zero); end
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL credit_stall: got %0h expected 0", gnt); end
    fifo_pop = 1'b1;
    step();
    fifo_pop = 1'b0;
    checks++; if (occupancy !== 7'd61) begin errors++; $display("FAIL credit_pop_occ: got %0d expected 61", occupancy); end
    checks++; if (credit_zero !== 1'b0) begin errors++; $display("FAIL credit_pop_cz: got %0b expected 0", credit_zero); end
    g = 0;
    repeat (6) begin
      step();
      if (gnt[0]) g++;
    end
    checks++; if (g !== 1) begin errors++; $display("FAIL credit_regrant: got %0d expected 1", g); end
    checks++; if (occupancy !== 7'd62) begin errors++; $display("FAIL credit_refill: got %0d expected 62", occupancy); end
    req = '0;
  endtask

  task automatic test_pop_empty();
    do_reset();
    fifo_pop = 1'b1;
    step();
    fifo_pop = 1'b0;
    checks++; if (pop_err !== 1'b1) begin errors++; $display("FAIL popempty_err: got %0b expected 1", pop_err); end
    checks++; if (occupancy !== 7'd0) begin errors++; $display("FAIL popempty_occ: got %0d expected 0", occupancy); end
    repeat (3) step();
    checks++; if (pop_err !== 1'b1) begin errors++; $display("FAIL popempty_sticky: got %0b expected 1", pop_err); end
    checks++; if (occupancy !== 7'd0) begin errors++; $display("FAIL popempty_occ2: got %0d expected 0", occupancy); end
  endtask

`ifdef SFIFO_ARB_PRIO_EN
  task automatic test_prio();
    logic [NREQ-1:0] prev;
    int              bad;
    do_reset();
    enable = 1'b1;
    req    = 4'b1111;
    prev   = '0;
    bad    = 0;
    repeat (24) begin
      step();
      checks++; if (gnt !== m_gnt) begin errors++; $display("FAIL prio_gnt: got %0h expected %0h", gnt, m_gnt); end
      if (prev != 4'b0 && gnt != 4'b0 && !prev[0] && !gnt[0]) bad++;
      prev = gnt;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL prio_alternate: got %0d violations expected 0", bad); end
    req = '0;
  endtask
`endif

  task automatic test_random();
    logic [DW-1:0] nv;
    do_reset();
    repeat (400) begin
      enable = ($urandom_range(15) != 0);
      for (int i = 0; i < NREQ; i++) begin
        nv = DW'($urandom);
        if (((req >> i) & 1) == 0) begin
          if ($urandom_range(2) == 0) begin
            req = req | NREQ'(1 << i);
            din = (din & ~(32'hFF << (i * DW))) | (32'(nv) << (i * DW));
          end
        end else if (((gnt >> i) & 1) != 0) begin
          if ($urandom_range(1) == 0) req = req & ~NREQ'(1 << i);
          else din = (din & ~(32'hFF << (i * DW))) | (32'(nv) << (i * DW));
        end
      end
      fifo_pop = (m_count > 0) && ($urandom_range(1) == 0);
      step();
      checks++; if (gnt !== m_gnt) begin errors++; $display("FAIL rnd_gnt: got %0h expected %0h", gnt, m_gnt); end
      checks++; if (fifo_w_en !== m_wen) begin errors++; $display("FAIL rnd_wen: got %0b expected %0b", fifo_w_en, m_wen); end
      checks++; if (fifo_din !== m_dout) begin errors++; $display("FAIL rnd_din: got %0h expected %0h", fifo_din, m_dout); end
      checks++; if (occupancy !== CW'(m_count)) begin errors++; $display("FAIL rnd_occ: got %0d expected %0d", occupancy, m_count); end
      checks++; if (credit_zero !== (m_count == DEPTH)) begin errors++; $display("FAIL rnd_cz: got %0b expected %0b", credit_zero, (m_count == DEPTH)); end
      checks++; if (pop_err !== m_perr) begin errors++; $display("FAIL rnd_perr: got %0b expected %0b", pop_err, m_perr); end
    end
    fifo_pop = 1'b0;
  endtask

  task automatic test_reset_mid();
    int guard;
    do_reset();
    enable = 1'b1;
    req    = 4'b1111;
    guard  = 0;
    step();
    step();
    while (gnt == 4'b0 && guard < 20) begin
      step();
      guard++;
    end
    checks++; if (gnt === 4'b0) begin errors++; $display("FAIL rstmid_setup: got %0h expected nonzero", gnt); end
    fifo_pop = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL rstmid_gnt: got %0h expected 0", gnt); end
    checks++; if (fifo_w_en !== 1'b0) begin errors++; $display("FAIL rstmid_wen: got %0b expected 0", fifo_w_en); end
    checks++; if (occupancy !== 7'd0) begin errors++; $display("FAIL rstmid_occ: got %0d expected 0", occupancy); end
    checks++; if (pop_err !== 1'b0) begin errors++; $display("FAIL rstmid_perr: got %0b expected 0", pop_err); end
    checks++; if (credit_zero !== 1'b0) begin errors++; $display("FAIL rstmid_cz: got %0b expected 0", credit_zero); end
    fifo_pop = 1'b0;
    req      = '0;
    enable   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_all_four();
    test_grant_pop();
    test_credit();
    test_pop_empty();
`ifdef SFIFO_ARB_PRIO_EN
    test_prio();
`endif
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
